// File: rtl/rom_bus_sequencer.sv
// rtl/rom_bus_sequencer.sv - single-port game ROM/RAM sequencer: ioctl download writes, CPU/video reads, core reset
module rom_bus_sequencer #(
    parameter int         AW          = 16,
    parameter int         HOLD_CYCLES = 1024,
    parameter logic [7:0] ROM_INDEX   = 8'd0
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [7:0]    cpu_data,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [7:0]    vid_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic          core_reset,
    output logic          rom_loaded
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;
    typedef enum logic [1:0] {P_FREE, P_ADDR, P_DATA} phase_t;

    localparam int            CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    state_t        r_state;
    phase_t        r_phase;
    logic [CW-1:0] r_cnt;
    logic          r_owner_vid;
    logic          r_last_vid;

    logic w_wr_ok;
    logic w_any_req;
    logic w_pick_vid;

    // A write also needs download still high so mem_we can never spill into HOLD.
    assign w_wr_ok    = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX)
                        && ((ioctl_addr >> AW) == 25'd0);
    assign w_any_req  = cpu_req || vid_req;
    assign w_pick_vid = vid_req && (!cpu_req || !r_last_vid);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_phase     <= P_FREE;
            r_cnt       <= '0;
            r_owner_vid <= 1'b0;
            r_last_vid  <= 1'b1;
            core_reset  <= 1'b1;
            rom_loaded  <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            cpu_ack     <= 1'b0;
            vid_ack     <= 1'b0;
            cpu_data    <= '0;
            vid_data    <= '0;
        end else begin
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    core_reset <= 1'b1;
                    if (ioctl_download) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    core_reset <= 1'b1;
                    if (w_wr_ok) begin
                        mem_we   <= 1'b1;
                        mem_addr <= ioctl_addr[AW-1:0];
                        mem_din  <= ioctl_dout;
                    end
                    if (!ioctl_download) begin
                        r_state    <= S_HOLD;
                        r_cnt      <= '0;
                        rom_loaded <= 1'b1;
                    end
                end
                S_HOLD: begin
                    core_reset <= 1'b1;
                    if (ioctl_download) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state    <= S_RUN;
                        r_phase    <= P_FREE;
                        core_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (ioctl_download) begin
                        // Abandon whatever read is in flight; its ack never appears.
                        r_state    <= S_LOAD;
                        r_phase    <= P_FREE;
                        core_reset <= 1'b1;
                    end else begin
                        case (r_phase)
                            P_FREE: begin
                                if (w_any_req) begin
                                    mem_addr    <= w_pick_vid ? vid_addr : cpu_addr;
                                    r_owner_vid <= w_pick_vid;
                                    r_last_vid  <= w_pick_vid;
                                    r_phase     <= P_ADDR;
                                end
                            end
                            P_ADDR: r_phase <= P_DATA;
                            P_DATA: begin
                                if (r_owner_vid) begin
                                    vid_data <= mem_dout;
                                    vid_ack  <= 1'b1;
                                end else begin
                                    cpu_data <= mem_dout;
                                    cpu_ack  <= 1'b1;
                                end
                                r_phase <= P_FREE;
                            end
                            default: r_phase <= P_FREE;
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/rom_bus_sequencer.md
Name: rom_bus_sequencer

Overview:
- Owns the single-port game ROM/RAM array in the arcade core.
- Sequences three users: the ioctl ROM download (write), the main CPU read port and the video/sound fetch read port.
- Generates the core reset, held from power-up through download plus a hold-off window.
- Sits between data_io/core top level and the shared memory.

Parameters:
AW, 16, memory address width (array depth 2^AW bytes)
HOLD_CYCLES, 1024, clk_sys cycles core_reset stays high after a download ends (>=1)
ROM_INDEX, 0, ioctl_index value whose writes reach memory

Ports:
clk_sys  in  1  system clock (48 MHz)
reset_n  in  1  synchronous active-low reset
ioctl_download  in  1  download in progress
ioctl_wr  in  1  one-cycle write strobe
ioctl_index  in  8  download target index
ioctl_addr  in  25  download byte address
ioctl_dout  in  8  download byte
cpu_req  in  1  CPU read request, level, held until cpu_ack
cpu_addr  in  AW  CPU read address, stable while cpu_req
cpu_ack  out  1  one-cycle pulse, cpu_data valid
cpu_data  out  8  CPU read data, held until next cpu_ack
vid_req  in  1  video read request, level
vid_addr  in  AW  video read address
vid_ack  out  1  one-cycle pulse, vid_data valid
vid_data  out  8  video read data, held until next vid_ack
mem_addr  out  AW  memory address (registered)
mem_we  out  1  memory write enable (registered)
mem_din  out  8  memory write data (registered)
mem_dout  in  8  memory read data, valid 1 cycle after mem_addr
core_reset  out  1  active-high reset to the game core
rom_loaded  out  1  sticky: at least one download completed

Behaviour:
- Reset (reset_n=0 at edge): state IDLE. core_reset=1, rom_loaded=0, mem_we=0, mem_addr=0, mem_din=0, cpu_ack=vid_ack=0, cpu_data=vid_data=0, hold counter=0, last_grant=VID. Any in-flight read is abandoned.
- States:
  - IDLE: core_reset=1. ioctl_download=1 -> LOAD.
  - LOAD: core_reset=1. Each ioctl_wr with ioctl_index==ROM_INDEX and ioctl_addr<2^AW gives next cycle: mem_we=1, mem_addr=ioctl_addr[AW-1:0], mem_din=ioctl_dout. Otherwise mem_we=0. Writes that are out of range or to another index are dropped silently. ioctl_download=0 -> HOLD, with counter cleared and rom_loaded set to 1.
  - HOLD: core_reset=1. Counter increments each cycle; at count HOLD_CYCLES-1 -> RUN. ioctl_download=1 -> LOAD, counter cleared.
  - RUN: core_reset=0 (it falls exactly HOLD_CYCLES cycles after the download falls). Read arbitration is active. ioctl_download=1 -> LOAD. core_reset=1 from the next cycle. Any pending or in-flight read is dropped with no ack, and any ack not yet issued is suppressed.
- Reads, RUN only, one transaction in flight:
  - Edge E0: arbiter samples req lines, picks a winner and registers mem_addr.
  - E1: memory outputs data.
  - E2: winner's data registers load mem_dout and its ack=1 for one cycle.
  - The arbiter does not sample at E2. Next sample is at E3, so a requester must drop or renew req while its ack is high.
  - Throughput: one read per 3 cycles; latency req->ack = 3 edges.
- Round-robin: if both reqs are high, grant the one not equal to last_grant. last_grant updates on each grant. A single requester always wins.
- mem_we is 0 in IDLE, HOLD and RUN. The block never writes outside LOAD.
- Requests raised in IDLE, LOAD or HOLD wait (no ack) until RUN.
- cpu_ack and vid_ack are never high in the same cycle.

Test Plan:
- Power-up: reset_n low 2 cycles, then high with no download -> core_reset=1, rom_loaded=0, no acks for 5000 cycles even with cpu_req=1.
- Download: 4 writes (index 0, addr 0..3, data A0..A3), then ioctl_download falls -> mem_we pulses one cycle after each ioctl_wr with matching addr/data; rom_loaded=1 next cycle; core_reset falls exactly 1024 cycles after the download falls.
- Filtering: write with index 1, then addr 0x10000 (AW=16) -> mem_we stays 0 for both.
- Arbitration: in RUN, cpu_req and vid_req high together and held (each renewed after ack) -> acks alternate CPU, VID, CPU, VID, spaced 3 cycles apart; data matches the memory model at each address.
- Single read: cpu_req at addr 0x0002 -> cpu_ack 3 edges later, cpu_data=A2; vid_ack stays 0.
- Abort: ioctl_download rises one cycle after a CPU grant in RUN -> no cpu_ack, core_reset=1 next cycle. Re-download in HOLD restarts the 1024-cycle count. reset_n=0 mid-LOAD -> IDLE, rom_loaded=0.
